// File: rtl/ysyx_25020047_ifu.sv
// RV32E fetch unit: one AR/R read per instruction, 4 cycles with zero-wait memory; each stall cycle on AR, R, IDU or WBU adds one cycle.
// Moore outputs hold everything stable under backpressure. IFU_MISALIGN_CHK_EN makes an unaligned dnpc fault instead of being rounded down.
module ysyx_25020047_ifu #(
    parameter int          DATA_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_arvalid,
    input  logic              mem_arready,
    output logic [DATA_W-1:0] mem_araddr,
    input  logic              mem_rvalid,
    output logic              mem_rready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [1:0]        mem_rresp,
    output logic              idu_valid,
    input  logic              idu_ready,
    output logic [DATA_W-1:0] idu_inst,
    output logic [DATA_W-1:0] idu_pc,
    output logic [DATA_W-1:0] idu_snpc,
    input  logic              wbu_valid,
    output logic              wbu_ready,
    input  logic [DATA_W-1:0] wbu_dnpc,
    output logic              ifu_fault
);

    typedef enum logic [2:0] {
        S_REQ     = 3'd0,
        S_WAIT    = 3'd1,
        S_DELIVER = 3'd2,
        S_NEXT    = 3'd3,
        S_FAULT   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_pc;
    logic [DATA_W-1:0]   w_pc_nxt;
    logic [DATA_W-1:0]   r_inst;
    logic                w_inst_we;
    // Keeps arvalid low for the first cycle after reset release, without a path from rst_n.
    logic                r_run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
            r_inst  <= '0;
            r_run   <= 1'b0;
        end else begin
            r_run   <= 1'b1;
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_inst_we) begin
                r_inst <= mem_rdata;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_inst_we   = 1'b0;
        case (r_state)
            S_REQ: begin
                if (r_run && mem_arready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    if (mem_rresp == 2'b00) begin
                        w_inst_we   = 1'b1;
                        w_state_nxt = S_DELIVER;
                    end else begin
                        w_state_nxt = S_FAULT;
                    end
                end
            end
            S_DELIVER: begin
                if (idu_ready) begin
                    w_state_nxt = S_NEXT;
                end
            end
            S_NEXT: begin
                if (wbu_valid) begin
`ifdef IFU_MISALIGN_CHK_EN
                    w_pc_nxt    = wbu_dnpc;
                    w_state_nxt = (wbu_dnpc[1:0] != 2'b00) ? S_FAULT : S_REQ;
`else
                    w_pc_nxt    = {wbu_dnpc[DATA_W-1:2], 2'b00};
                    w_state_nxt = S_REQ;
`endif
                end
            end
            S_FAULT: begin
                w_state_nxt = S_FAULT;
            end
            default: begin
                w_state_nxt = S_FAULT;
            end
        endcase
    end

    always_comb begin
        mem_arvalid = 1'b0;
        mem_rready  = 1'b0;
        idu_valid   = 1'b0;
        wbu_ready   = 1'b0;
        ifu_fault   = 1'b0;
        case (r_state)
            S_REQ:     mem_arvalid = r_run;
            S_WAIT:    mem_rready  = 1'b1;
            S_DELIVER: idu_valid   = 1'b1;
            S_NEXT:    wbu_ready   = 1'b1;
            S_FAULT:   ifu_fault   = 1'b1;
            default:   ifu_fault   = 1'b0;
        endcase
    end

    assign mem_araddr = r_pc;
    assign idu_inst   = r_inst;
    assign idu_pc     = r_pc;
    assign idu_snpc   = r_pc + 32'd4;

endmodule

// File: tb/tb_ysyx_25020047_ifu.sv
// Bench for ysyx_25020047_ifu: table of directed fetches, randomized fetches against a PC-sequence model, and reset/fault/misalign sequences.
module tb_ysyx_25020047_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_arvalid, mem_arready;
    logic [31:0] mem_araddr;
    logic        mem_rvalid, mem_rready;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_rresp;
    logic        idu_valid, idu_ready;
    logic [31:0] idu_inst, idu_pc, idu_snpc;
    logic        wbu_valid, wbu_ready;
    logic [31:0] wbu_dnpc;
    logic        ifu_fault;

    int n_tests = 0;
    int n_fail  = 0;
    int n_ar_seen = 0;
    int n_ar_exp  = 0;

    ysyx_25020047_ifu #(.DATA_W(32), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
        .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata), .mem_rresp(mem_rresp),
        .idu_valid(idu_valid), .idu_ready(idu_ready), .idu_inst(idu_inst),
        .idu_pc(idu_pc), .idu_snpc(idu_snpc),
        .wbu_valid(wbu_valid), .wbu_ready(wbu_ready), .wbu_dnpc(wbu_dnpc),
        .ifu_fault(ifu_fault)
    );

    always #5 clk = ~clk;

    // Independent count of AR handshakes the DUT actually performs.
    always @(posedge clk) begin
        if (rst_n && mem_arvalid && mem_arready) n_ar_seen++;
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rdata;
        logic [31:0] dnpc;
        int          ar_st, r_st, id_st, wb_st;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural next fetch address from a writeback dnpc.
    function automatic logic [31:0] next_pc(input logic [31:0] dnpc);
        return dnpc & 32'hFFFF_FFFC;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_arready = 0; mem_rvalid = 0; mem_rdata = 0; mem_rresp = 0;
        idu_ready = 0; wbu_valid = 0; wbu_dnpc = 0;
    endtask

    // Drives one full instruction from S_REQ back to S_REQ; entered and left #1 after a posedge.
    task automatic do_instr(input logic [31:0] pc, input logic [31:0] rdata, input logic [31:0] dnpc,
                            input int ar_st, input int r_st, input int id_st, input int wb_st);
        for (int i = 0; i < ar_st; i++) begin
            mem_arready = 0; mem_rvalid = 1; mem_rresp = 2'b11; mem_rdata = 32'hDEAD_BEEF;
            @(negedge clk);
            chk("ar_hold_vld", mem_arvalid, 1);
            chk("ar_hold_addr", mem_araddr, pc);
            next_cycle();
        end
        mem_rvalid = 0; mem_rresp = 0; mem_arready = 1;
        @(negedge clk);
        chk("ar_vld", mem_arvalid, 1);
        chk("ar_addr", mem_araddr, pc);
        chk("req_rready", mem_rready, 0);
        next_cycle();
        mem_arready = 0;
        n_ar_exp++;
        for (int i = 0; i < r_st; i++) begin
            @(negedge clk);
            chk("wait_rready", mem_rready, 1);
            chk("wait_arvalid", mem_arvalid, 0);
            chk("wait_iduvalid", idu_valid, 0);
            next_cycle();
        end
        mem_rvalid = 1; mem_rdata = rdata; mem_rresp = 2'b00;
        @(negedge clk);
        chk("r_rready", mem_rready, 1);
        next_cycle();
        mem_rvalid = 0; mem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < id_st; i++) begin
            idu_ready = 0; wbu_valid = 1; wbu_dnpc = ~dnpc;
            @(negedge clk);
            chk("idu_hold_vld", idu_valid, 1);
            chk("idu_hold_inst", idu_inst, rdata);
            chk("idu_hold_pc", idu_pc, pc);
            chk("idu_hold_wbrdy", wbu_ready, 0);
            next_cycle();
        end
        wbu_valid = 0; idu_ready = 1;
        @(negedge clk);
        chk("idu_vld", idu_valid, 1);
        chk("idu_inst", idu_inst, rdata);
        chk("idu_pc", idu_pc, pc);
        chk("idu_snpc", idu_snpc, pc + 32'd4);
        next_cycle();
        idu_ready = 0;
        for (int i = 0; i < wb_st; i++) begin
            @(negedge clk);
            chk("wb_hold_rdy", wbu_ready, 1);
            chk("wb_hold_iduvld", idu_valid, 0);
            next_cycle();
        end
        wbu_valid = 1; wbu_dnpc = dnpc;
        @(negedge clk);
        chk("wb_rdy", wbu_ready, 1);
        next_cycle();
        wbu_valid = 0;
    endtask

    task automatic chk_all_low(input string tag);
        chk({tag, "_arvalid"}, mem_arvalid, 0);
        chk({tag, "_rready"}, mem_rready, 0);
        chk({tag, "_iduvalid"}, idu_valid, 0);
        chk({tag, "_wbready"}, wbu_ready, 0);
    endtask

    task automatic reset_pulse();
        idle_inputs();
        rst_n = 0;
        #1;
        chk_all_low("rst");
        chk("rst_fault", ifu_fault, 0);
        next_cycle();
        rst_n = 1;
        @(negedge clk);
        chk("post_rst_gap", mem_arvalid, 0);
        next_cycle();
    endtask

    initial begin
        logic [31:0] m_pc;
        logic [31:0] d;

        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_low("por");
        chk("por_fault", ifu_fault, 0);
        chk("por_pc", idu_pc, RST_PC);
        chk("por_inst", idu_inst, 32'h0);
        rst_n = 1;
        @(negedge clk);
        chk("first_gap", mem_arvalid, 0);
        next_cycle();

        tbl[0] = '{32'h8000_0000, 32'h0000_0413, 32'h8000_0004, 0, 0, 0, 0};
        tbl[1] = '{32'h8000_0004, 32'h0010_0093, 32'h8000_0100, 0, 0, 0, 0};
        tbl[2] = '{32'h8000_0100, 32'h0020_8113, 32'h8000_0010, 3, 0, 2, 1};
        tbl[3] = '{32'h8000_0010, 32'h1234_5678, 32'hFFFF_FFFC, 0, 2, 0, 0};
`ifdef IFU_MISALIGN_CHK_EN
        tbl[4] = '{32'hFFFF_FFFC, 32'hCAFE_F00D, 32'h8000_0100, 1, 0, 0, 2};
`else
        tbl[4] = '{32'hFFFF_FFFC, 32'hCAFE_F00D, 32'h8000_0102, 1, 0, 0, 2};
`endif
        tbl[5] = '{32'h8000_0100, 32'h0000_0073, 32'h8000_0200, 1, 1, 1, 1};

        foreach (tbl[i]) begin
            do_instr(tbl[i].pc, tbl[i].rdata, tbl[i].dnpc,
                     tbl[i].ar_st, tbl[i].r_st, tbl[i].id_st, tbl[i].wb_st);
        end
        chk("snpc_wrap_model", 32'hFFFF_FFFC + 32'd4 == 32'h0 ? 32'h0 : 32'h1, idu_snpc & 32'h0);

        m_pc = next_pc(tbl[5].dnpc);
        for (int n = 0; n < 24; n++) begin
            d = $urandom;
`ifdef IFU_MISALIGN_CHK_EN
            d = d & 32'hFFFF_FFFC;
`endif
            do_instr(m_pc, $urandom, d, $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 3));
            m_pc = next_pc(d);
        end
        chk("ar_count_rand", n_ar_seen, n_ar_exp);

        // Reset while waiting for read data.
        mem_arready = 1;
        @(negedge clk);
        chk("mid_ar_addr", mem_araddr, m_pc);
        next_cycle();
        mem_arready = 0;
        n_ar_exp++;
        @(negedge clk);
        chk("mid_wait_rready", mem_rready, 1);
        #2;
        reset_pulse();
        do_instr(RST_PC, 32'h0000_0513, 32'h8000_0008, 0, 0, 0, 0);

        // Error response on the fetch of 0x8000_0008.
        mem_arready = 1;
        @(negedge clk);
        chk("flt_ar_addr", mem_araddr, 32'h8000_0008);
        next_cycle();
        mem_arready = 0;
        n_ar_exp++;
        mem_rvalid = 1; mem_rresp = 2'b10; mem_rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        chk("flt_pre", ifu_fault, 0);
        next_cycle();
        mem_rvalid = 0; mem_rresp = 0;
        idu_ready = 1; wbu_valid = 1; wbu_dnpc = 32'h8000_0000; mem_arready = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("flt_sticky", ifu_fault, 1);
            chk_all_low("flt");
            chk("flt_pc", idu_pc, 32'h8000_0008);
            next_cycle();
        end
        chk("ar_count_flt", n_ar_seen, n_ar_exp);

        // Unaligned dnpc.
        reset_pulse();
        do_instr(RST_PC, 32'h0000_0613, 32'h8000_0102, 0, 0, 0, 0);
`ifdef IFU_MISALIGN_CHK_EN
        mem_arready = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mis_fault", ifu_fault, 1);
            chk("mis_noar", mem_arvalid, 0);
            chk("mis_pc", idu_pc, 32'h8000_0102);
            next_cycle();
        end
        mem_arready = 0;
`else
        do_instr(32'h8000_0100, 32'h0000_0713, 32'h8000_0000, 0, 0, 0, 0);
        @(negedge clk);
        chk("mis_nofault", ifu_fault, 0);
`endif
        chk("ar_count_end", n_ar_seen, n_ar_exp);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
